prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Sequencer and owner of the 16x8 TD4 program memory's single port. Loads programs from a
//  nibble-wide valid/ready stream: two nibbles per word, opcode first, then immediate.
//  Writes each word at an auto-incrementing address, then releases the CPU to run.
//  In RUN the memory address follows the CPU PC; during a load the CPU is held stopped.
// PARAMETERS
//  WORDS   16  memory depth in words; last address is WORDS-1
//  ADDR_W  4   address width; WORDS <= 2**ADDR_W
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       synchronous, active-high reset
//  load_req       in   1       start a load session (IDLE or RUN)
//  run_req        in   1       IDLE -> RUN without loading
//  nib_valid      in   1       stream nibble valid
//  nib_data       in   4       stream nibble
//  nib_last       in   1       marks last word; sampled with the immediate nibble only
//  nib_ready      out  1       loader accepts a nibble this cycle
//  cpu_pc         in   ADDR_W  CPU fetch address
//  cpu_run        out  1       CPU enable; 0 holds the CPU stopped
//  mem_address    out  ADDR_W  to memory address
//  mem_opcode     out  4       to memory opcode_in
//  mem_immediate  out  4       to memory immediate_in
//  mem_write      out  1       to memory write
//  busy           out  1       load session in progress
//  done           out  1       one-cycle pulse at load completion
//  word_count     out  ADDR_W+1  words written in current/last session (0..WORDS)
// BEHAVIOUR
//  - Reset values: state IDLE, load addr 0, all outputs 0, word_count 0.
//  - Memory contents are not touched by rst; partially loaded words remain.
//  - States: IDLE, LO, HI, WRITE, FINISH, RUN. All outputs except mem_address are registered/Moore.
//  - mem_address mux: LO/HI/WRITE/FINISH -> load addr; IDLE/RUN -> cpu_pc.
//  - IDLE: cpu_run=0.
//    - load_req -> LO; load addr=0, word_count=0, busy=1.
//    - else run_req -> RUN. load_req wins over run_req.
//  - LO: nib_ready=1. On nib_valid: mem_opcode<=nib_data, -> HI. nib_last is ignored here.
//  - HI: nib_ready=1. On nib_valid: mem_immediate<=nib_data, last flag<=nib_last, -> WRITE.
//  - WRITE: mem_write=1 for exactly one cycle; nib_ready=0; word_count+1.
//    - Then, if last flag or addr==WORDS-1 -> FINISH.
//    - Otherwise addr+1 -> LO. The address never wraps.
//  - FINISH: done=1 for one cycle, busy<=0 -> RUN.
//  - RUN: cpu_run=1. load_req -> LO; addr=0, word_count=0, busy=1, cpu_run=0 from the next cycle.
//  - Throughput: min 3 cycles/word (LO,HI,WRITE) with back-to-back valid.
//  - A nibble is transferred only when nib_valid && nib_ready; no advance without valid.
//  - load_req is ignored while busy. rst mid-session aborts to IDLE immediately; no write issued.
//  - Stored word = {immediate, opcode}, matching memory data layout.
// TESTING
//  1. rst high 2 cycles -> all outputs 0, mem_write never asserted, mem_address==cpu_pc.
//  2. load_req; nibbles 1,A,2,B,3,C (last on C) back-to-back ->
//     - writes 0xA1@0, 0xB2@1, 0xC3@2, each 1 cycle;
//     - done pulse, word_count=3, cpu_run=1 after FINISH.
//  3. 32 nibbles with no nib_last -> 16 writes addr 0..15, word_count=16;
//     - auto FINISH; nib_ready=0 afterwards, so a 33rd nibble is not accepted.
//  4. Random nib_valid gaps over 4 words -> same writes as gapless.
//     - No state advance while nib_valid=0; nib_ready=0 in WRITE.
//  5. In RUN with cpu_pc=7, load_req -> cpu_run 0 next cycle, mem_address switches to load addr 0.
//     - New load then completes normally.
//  6. rst after 2 words of a session -> IDLE with reset outputs.
//     - Next load_req writes from addr 0; load_req+run_req together in IDLE -> LO.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader for the TD4 16x8 program memory: accepts opcode/immediate nibble pairs
// from a valid/ready stream, writes them at auto-incrementing addresses, then runs the CPU.
module prog_loader #(
    parameter int unsigned WORDS  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              run_req,
    input  logic              nib_valid,
    input  logic [3:0]        nib_data,
    input  logic              nib_last,
    output logic              nib_ready,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_opcode,
    output logic [3:0]        mem_immediate,
    output logic              mem_write,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WRITE,
        S_FINISH,
        S_RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] load_addr;
    logic              last_flag;
    logic              session_end;

    // The address stops at the last word instead of wrapping, which also ends the session.
    assign session_end = last_flag || (load_addr == LAST_ADDR);

    always_comb begin
        state_nxt   = state;
        nib_ready   = 1'b0;
        cpu_run     = 1'b0;
        mem_write   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mem_address = load_addr;
        case (state)
            S_IDLE: begin
                mem_address = cpu_pc;
                if (load_req)
                    state_nxt = S_LO;
                else if (run_req)
                    state_nxt = S_RUN;
            end
            S_LO: begin
                nib_ready = 1'b1;
                busy      = 1'b1;
                if (nib_valid)
                    state_nxt = S_HI;
            end
            S_HI: begin
                nib_ready = 1'b1;
                busy      = 1'b1;
                if (nib_valid)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                state_nxt = session_end ? S_FINISH : S_LO;
            end
            S_FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mem_address = cpu_pc;
                cpu_run     = 1'b1;
                if (load_req)
                    state_nxt = S_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            load_addr     <= '0;
            last_flag     <= 1'b0;
            word_count    <= '0;
            mem_opcode    <= '0;
            mem_immediate <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_RUN: begin
                    if (state_nxt == S_LO) begin
                        load_addr  <= '0;
                        word_count <= '0;
                        last_flag  <= 1'b0;
                    end
                end
                S_LO: begin
                    if (nib_valid)
                        mem_opcode <= nib_data;
                end
                S_HI: begin
                    if (nib_valid) begin
                        mem_immediate <= nib_data;
                        last_flag     <= nib_last;
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + (ADDR_W + 1)'(1);
                    if (!session_end)
                        load_addr <= load_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: checks reset, normal/full/gapped loads, reload from RUN
// and abort by reset against hand-computed memory writes.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req, run_req;
    logic       nib_valid, nib_last;
    logic [3:0] nib_data;
    logic       nib_ready;
    logic [3:0] cpu_pc;
    logic       cpu_run;
    logic [3:0] mem_address, mem_opcode, mem_immediate;
    logic       mem_write, busy, done;
    logic [4:0] word_count;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         b2b_writes = 0;
    logic       prev_wr = 1'b0;

    prog_loader #(.WORDS(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req),
        .nib_valid(nib_valid), .nib_data(nib_data), .nib_last(nib_last),
        .nib_ready(nib_ready), .cpu_pc(cpu_pc), .cpu_run(cpu_run),
        .mem_address(mem_address), .mem_opcode(mem_opcode),
        .mem_immediate(mem_immediate), .mem_write(mem_write),
        .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory write monitor: records each written word as {immediate, opcode}.
    always @(negedge clk) begin
        if (mem_write) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back({mem_immediate, mem_opcode});
            if (prev_wr) b2b_writes++;
        end
        prev_wr = mem_write;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] d, input logic last, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            nib_valid = 1'b0;
            @(negedge clk);
            check("hold_ready", nib_ready, 1'b1);
            check("hold_nowrite", mem_write, 1'b0);
        end
        nib_valid = 1'b1;
        nib_data  = d;
        nib_last  = last;
        t = 0;
        while (!nib_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("nib_accept_timeout", (t < 20), 1'b1);
        @(negedge clk);
        nib_valid = 1'b0;
        nib_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("done_pulse", done, 1'b1);
    endtask

    task automatic expect_write(input int idx, input logic [3:0] a, input logic [7:0] d);
        if (idx < wr_addr.size()) begin
            check($sformatf("wr%0d_addr", idx), wr_addr[idx], a);
            check($sformatf("wr%0d_data", idx), wr_data[idx], d);
        end else begin
            check($sformatf("wr%0d_missing", idx), wr_addr.size(), idx + 1);
        end
    endtask

    task automatic start_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic after_finish(input logic [4:0] wc);
        check("word_count", word_count, wc);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("run_after_finish", cpu_run, 1'b1);
        check("busy_cleared", busy, 1'b0);
    endtask

    logic [3:0] gap_op[4]  = '{4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] gap_imm[4] = '{4'h9, 4'hA, 4'hB, 4'hC};
    int         gaps[8]    = '{0, 2, 1, 3, 0, 1, 2, 1};

    initial begin
        rst = 1'b1; load_req = 1'b0; run_req = 1'b0;
        nib_valid = 1'b0; nib_data = '0; nib_last = 1'b0; cpu_pc = 4'h5;

        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_cpu_run", cpu_run, 1'b0);
        check("rst_nib_ready", nib_ready, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_word_count", word_count, 5'd0);
        check("rst_opcode", mem_opcode, 4'h0);
        check("rst_immediate", mem_immediate, 4'h0);
        check("rst_addr_pc", mem_address, 4'h5);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_writes", wr_addr.size(), 0);

        // 2: three-word load, last on C
        start_load();
        check("load_busy", busy, 1'b1);
        check("load_addr0", mem_address, 4'h0);
        check("load_cpu_stopped", cpu_run, 1'b0);
        send_nib(4'h1, 1'b0, 0); send_nib(4'hA, 1'b0, 0);
        send_nib(4'h2, 1'b0, 0); send_nib(4'hB, 1'b0, 0);
        send_nib(4'h3, 1'b0, 0); send_nib(4'hC, 1'b1, 0);
        wait_done();
        after_finish(5'd3);
        check("t2_nwrites", wr_addr.size(), 3);
        expect_write(0, 4'h0, 8'hA1);
        expect_write(1, 4'h1, 8'hB2);
        expect_write(2, 4'h2, 8'hC3);

        // 3: full memory without nib_last, auto finish at address 15
        wr_addr.delete(); wr_data.delete();
        start_load();
        for (int k = 0; k < 16; k++) begin
            send_nib(4'(k), 1'b0, 0);
            send_nib(4'(15 - k), 1'b0, 0);
        end
        wait_done();
        after_finish(5'd16);
        nib_valid = 1'b1; nib_data = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_33rd_ready", nib_ready, 1'b0);
        end
        nib_valid = 1'b0;
        check("t3_nwrites", wr_addr.size(), 16);
        for (int k = 0; k < 16; k++)
            expect_write(k, 4'(k), {4'(15 - k), 4'(k)});

        // 4: four words with valid gaps
        wr_addr.delete(); wr_data.delete();
        start_load();
        for (int w = 0; w < 4; w++) begin
            send_nib(gap_op[w], 1'b0, gaps[2*w]);
            send_nib(gap_imm[w], (w == 3), gaps[2*w+1]);
            check("write_not_ready", nib_ready, 1'b0);
            check("write_strobe", mem_write, 1'b1);
            if (w < 3) @(negedge clk);
        end
        wait_done();
        after_finish(5'd4);
        check("t4_nwrites", wr_addr.size(), 4);
        expect_write(0, 4'h0, 8'h95);
        expect_write(1, 4'h1, 8'hA6);
        expect_write(2, 4'h2, 8'hB7);
        expect_write(3, 4'h3, 8'hC8);

        // 5: reload from RUN
        wr_addr.delete(); wr_data.delete();
        cpu_pc = 4'h7;
        @(negedge clk);
        check("run_addr_pc", mem_address, 4'h7);
        check("run_cpu_run", cpu_run, 1'b1);
        start_load();
        check("reload_cpu_stop", cpu_run, 1'b0);
        check("reload_addr0", mem_address, 4'h0);
        check("reload_busy", busy, 1'b1);
        send_nib(4'h4, 1'b0, 0); send_nib(4'hD, 1'b0, 0);
        send_nib(4'hE, 1'b0, 0); send_nib(4'h1, 1'b1, 0);
        wait_done();
        after_finish(5'd2);
        expect_write(0, 4'h0, 8'hD4);
        expect_write(1, 4'h1, 8'h1E);

        // 6: reset aborts a session, then load_req beats run_req
        wr_addr.delete(); wr_data.delete();
        start_load();
        send_nib(4'h2, 1'b0, 0); send_nib(4'h7, 1'b0, 0);
        send_nib(4'h3, 1'b0, 0); send_nib(4'h8, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_cpu_run", cpu_run, 1'b0);
        check("abort_ready", nib_ready, 1'b0);
        check("abort_wc", word_count, 5'd0);
        check("abort_addr_pc", mem_address, 4'h7);
        check("abort_nwrites", wr_addr.size(), 2);
        expect_write(0, 4'h0, 8'h72);
        expect_write(1, 4'h1, 8'h83);
        wr_addr.delete(); wr_data.delete();
        load_req = 1'b1; run_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0; run_req = 1'b0;
        check("prio_busy", busy, 1'b1);
        check("prio_cpu_run", cpu_run, 1'b0);
        check("prio_addr0", mem_address, 4'h0);
        send_nib(4'h9, 1'b0, 0); send_nib(4'h3, 1'b1, 0);
        wait_done();
        after_finish(5'd1);
        check("t6_nwrites", wr_addr.size(), 1);
        expect_write(0, 4'h0, 8'h39);

        check("write_single_cycle", b2b_writes, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
